// File: rtl/firebird_mc_main_ctrl.sv
// firebird_mc_main_ctrl: multi-cycle Firebird main control FSM that decodes the IR opcode and drives the datapath strobes
module firebird_mc_main_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_en,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    state_d    = IDLE;
    retire     = 1'b0;
    illegal_d  = illegal_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_en      = 1'b0;
    pc_source  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                    (opcode == OP_R)                     ? EXEC     :
                    (opcode == OP_BEQ)                   ? BRANCH   : HALT;
        illegal_d = illegal_q | (state_d == HALT);
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        mdr_write = mem_ready;
        state_d   = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? FETCH : MEM_WR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 1'b1;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end
  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_firebird_mc_main_ctrl.sv
// tb_firebird_mc_main_ctrl: table-driven check of the Firebird main control FSM plus halt and async-reset sequences
module tb_firebird_mc_main_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'b0110011;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_read, mem_write, i_or_d, ir_write, mdr_write, pc_en, pc_source, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, illegal;
  logic [31:0] instret;
  logic [3:0]  state_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [31:0] ir;
  } vec_t;
  vec_t vq[$];
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BQ = 7'b1100011, BAD = 7'b1111111;
  // ctl = {mem_read,mem_write,i_or_d, ir_write,mdr_write,pc_en, pc_source,alu_src_a, alu_src_b, alu_op, reg_write,mem_to_reg,illegal}
  localparam logic [14:0] C_IDLE = 15'b000_000_00_00_00_000;
  localparam logic [14:0] C_FR   = 15'b100_101_00_01_00_000;
  localparam logic [14:0] C_FW   = 15'b100_000_00_01_00_000;
  localparam logic [14:0] C_DEC  = 15'b000_000_00_10_00_000;
  localparam logic [14:0] C_EX   = 15'b000_000_01_00_10_000;
  localparam logic [14:0] C_RWB  = 15'b000_000_00_00_00_100;
  localparam logic [14:0] C_MA   = 15'b000_000_01_10_00_000;
  localparam logic [14:0] C_RDW  = 15'b101_000_00_00_00_000;
  localparam logic [14:0] C_RDR  = 15'b101_010_00_00_00_000;
  localparam logic [14:0] C_MWB  = 15'b000_000_00_00_00_110;
  localparam logic [14:0] C_BR1  = 15'b000_001_11_00_01_000;
  localparam logic [14:0] C_BR0  = 15'b000_000_11_00_01_000;
  localparam logic [14:0] C_WR   = 15'b011_000_00_00_00_000;
  localparam logic [14:0] C_HALT = 15'b000_000_00_00_00_001;

  firebird_mc_main_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_read && mem_write) begin
      n_bad++;
      $display("FAIL rd_wr_excl: mem_read and mem_write both 1 at %0t", $time);
    end

  function automatic logic [14:0] ctl_now();
    return {mem_read, mem_write, i_or_d, ir_write, mdr_write, pc_en, pc_source, alu_src_a,
            alu_src_b, alu_op, reg_write, mem_to_reg, illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic z, input logic mr, input logic [3:0] st,
                     input logic [14:0] ctl, input logic [31:0] ir);
    vq.push_back('{op: op, z: z, mr: mr, st: st, ctl: ctl, ir: ir});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(RT, 0, 1, 0, C_IDLE, 0);
    add(RT, 0, 1, 1, C_FR,   0);
    add(RT, 0, 1, 2, C_DEC,  0);
    add(RT, 0, 1, 7, C_EX,   0);
    add(RT, 0, 1, 8, C_RWB,  0);
    add(LW, 0, 0, 1, C_FW,   1);
    add(LW, 0, 0, 1, C_FW,   1);
    add(LW, 0, 1, 1, C_FR,   1);
    add(LW, 0, 1, 2, C_DEC,  1);
    add(LW, 0, 0, 3, C_MA,   1);
    add(LW, 0, 0, 4, C_RDW,  1);
    add(LW, 0, 0, 4, C_RDW,  1);
    add(LW, 0, 1, 4, C_RDR,  1);
    add(LW, 0, 1, 5, C_MWB,  1);
    add(BQ, 1, 1, 1, C_FR,   2);
    add(BQ, 1, 1, 2, C_DEC,  2);
    add(BQ, 1, 1, 9, C_BR1,  2);
    add(BQ, 0, 1, 1, C_FR,   3);
    add(BQ, 0, 1, 2, C_DEC,  3);
    add(BQ, 0, 1, 9, C_BR0,  3);
    add(SW, 0, 1, 1, C_FR,   4);
    add(SW, 0, 1, 2, C_DEC,  4);
    add(SW, 0, 0, 3, C_MA,   4);
    add(SW, 0, 0, 6, C_WR,   4);
    add(SW, 0, 1, 6, C_WR,   4);
    add(BAD, 0, 1, 1, C_FR,  5);
    add(BAD, 0, 1, 2, C_DEC, 5);
    #2;
    chk("rst_state", {28'd0, state_o}, 0);
    chk("rst_ctl", {17'd0, ctl_now()}, {17'd0, C_IDLE});
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    foreach (vq[i]) begin
      opcode = vq[i].op;
      zero = vq[i].z;
      mem_ready = vq[i].mr;
      #2;
      chk($sformatf("v%0d_state", i), {28'd0, state_o}, {28'd0, vq[i].st});
      chk($sformatf("v%0d_ctl", i), {17'd0, ctl_now()}, {17'd0, vq[i].ctl});
      chk($sformatf("v%0d_instret", i), instret, vq[i].ir);
      tick();
    end
    opcode = RT;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero = i[1];
      #2;
      chk($sformatf("halt%0d_state", i), {28'd0, state_o}, 32'd10);
      chk($sformatf("halt%0d_ctl", i), {17'd0, ctl_now()}, {17'd0, C_HALT});
      chk($sformatf("halt%0d_instret", i), instret, 5);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("halt_rst_state", {28'd0, state_o}, 0);
    chk("halt_rst_illegal", {31'd0, illegal}, 0);
    chk("halt_rst_instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    opcode = SW;
    mem_ready = 1'b1;
    repeat (4) tick();
    mem_ready = 1'b0;
    #2;
    chk("mw_pre_state", {28'd0, state_o}, 6);
    chk("mw_pre_ctl", {17'd0, ctl_now()}, {17'd0, C_WR});
    rst = 1'b1;
    #1;
    chk("mw_rst_state", {28'd0, state_o}, 0);
    chk("mw_rst_ctl", {17'd0, ctl_now()}, {17'd0, C_IDLE});
    chk("mw_rst_instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("post_rst_idle", {28'd0, state_o}, 0);
    tick();
    chk("post_rst_fetch", {28'd0, state_o}, 1);
    chk("post_rst_ctl", {17'd0, ctl_now()}, {17'd0, C_FR});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/firebird_mc_main_ctrl.md
Name: firebird_mc_main_ctrl

Overview:
- Main control FSM for the multi-cycle Firebird core.
- Decodes the 7-bit opcode held in the instruction register.
- Sequences fetch, decode, execute, memory and writeback one state per cycle, stalling on memory handshakes.
- Drives the datapath muxes/enables and produces alu_op[1:0] for firebird_alu_ctrl (00 add, 01 subtract, 10 use funct fields). It is the producer side of that interface.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  7  IR[6:0]; valid from DECODE onward.
- zero  input  1  ALU zero flag (combinational from datapath).
- mem_ready  input  1  memory completes the current read/write this cycle.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR (fetch data).
- mdr_write  output  1  load MDR (load data).
- pc_en  output  1  PC register enable (pc_write | pc_write_cond & zero).
- pc_source  output  1  PC next: 0 = ALU result, 1 = ALUOut.
- alu_src_a  output  1  0 = PC, 1 = rs1.
- alu_src_b  output  2  00 = rs2, 01 = const 4, 10 = imm.
- alu_op  output  2  to firebird_alu_ctrl.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- illegal  output  1  sticky: unsupported opcode seen.
- instret  output  CNT_W  retired-instruction count.
- state_o  output  4  current state encoding (debug).

Behaviour:
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC 7, R_WB 8, BRANCH 9, HALT 10. Unused encodings return to IDLE.
- Reset (async):
  - state = IDLE, illegal = 0, instret = 0.
  - All outputs are 0 while in IDLE. IDLE -> FETCH unconditionally on the next clk.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 0.
  - ir_write = pc_en = mem_ready.
  - Stay in FETCH while mem_ready = 0; request signals are held stable. -> DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 10, alu_op = 00 (branch target into ALUOut).
  - Transitions on opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEM_ADDR
    - 0110011 (R-type) -> EXEC
    - 1100011 (beq) -> BRANCH
    - any other opcode -> HALT, and set illegal.
- MEM_ADDR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - -> MEM_RD for lw, -> MEM_WR for sw. opcode is re-sampled here; IR is stable.
- MEM_RD:
  - Outputs: mem_read = 1, i_or_d = 1, mdr_write = mem_ready.
  - Hold while mem_ready = 0; -> MEM_WB when mem_ready = 1.
- MEM_WB: reg_write = 1, mem_to_reg = 1; instret += 1; -> FETCH.
- MEM_WR:
  - Outputs: mem_write = 1, i_or_d = 1.
  - Hold while mem_ready = 0. When mem_ready = 1: instret += 1, -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; -> R_WB.
- R_WB: reg_write = 1, mem_to_reg = 0; instret += 1; -> FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 1, pc_en = zero.
  - instret += 1; -> FETCH.
- HALT: all strobes 0; stays in HALT until rst. illegal stays 1.
- Output timing:
  - All outputs are Moore decodes of state, except pc_en, ir_write and mdr_write, which also depend on mem_ready/zero in the same cycle.
  - mem_read and mem_write are never both 1.
- Cycle counts with zero-wait memory (mem_ready = 1 in the first cycle): R-type 4, lw 5, sw 4, beq 3. Each wait cycle adds 1.
- instret wraps modulo 2^CNT_W; no saturation.
- Reset asserted mid-instruction forces IDLE immediately. No partial reg_write or mem_write is issued after reset rises.

Test Plan:
- Reset, then hold mem_ready = 1 and opcode = 0110011 -> states 0,1,2,7,8,1; alu_op = 10 in EXEC, reg_write = 1 in R_WB only; instret = 1 after 5 clocks.
- lw (0000011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD -> FETCH held 3 cycles with ir_write = pc_en = 1 only in the last; mdr_write = 1 only in the final MEM_RD cycle; mem_to_reg = 1 in MEM_WB; 10 cycles total.
- beq with zero = 1, then zero = 0 -> BRANCH: alu_op = 01, pc_source = 1; pc_en = 1 in the first case and 0 in the second; instret increments in both.
- sw (0100011) -> mem_write = 1, i_or_d = 1 in MEM_WR; reg_write never asserted; instret += 1.
- opcode = 1111111 in DECODE -> HALT (10); illegal = 1 and stays 1; no strobes for 20 cycles; instret unchanged; reset clears illegal.
- Assert rst during MEM_WR with mem_ready = 0 -> state_o = 0 and all outputs 0 immediately (asynchronous); FETCH follows one cycle after rst deasserts.
